// File: rtl/mc_ctrl_hs.sv
// Multicycle MIPS control FSM with a request/ack memory handshake and timeout,
// a stall handshake to a mul/div unit, and an exception state.
module mc_ctrl_hs #(
  parameter int ALUOP_W     = 4,
  parameter int TO_W        = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int MULDIV_EN   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Zero,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               mem_ack,
  input  logic               md_busy,
  output logic               MemReq,
  output logic               MemWrite,
  output logic               IorD,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               EXTOp,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [2:0]         PCSource,
  output logic [1:0]         GPRSel,
  output logic [1:0]         WDSel,
  output logic               md_start,
  output logic [1:0]         md_op,
  output logic               exc_valid,
  output logic [1:0]         exc_cause,
  output logic [2:0]         state_o
);
  typedef enum logic [2:0] {
    S_IF = 3'd0, S_ID = 3'd1, S_EXE = 3'd2, S_MEM = 3'd3,
    S_WB = 3'd4, S_MDW = 3'd5, S_EXC = 3'd6
  } state_t;

  localparam logic [3:0] A_ADD = 4'd1, A_SUB = 4'd2, A_AND = 4'd3, A_OR = 4'd4,
                         A_SLT = 4'd5, A_SLTU = 4'd6, A_SLL = 4'd7, A_SRL = 4'd8,
                         A_NOR = 4'd9, A_LUI = 4'd10;
  localparam logic [1:0] C_ILL = 2'd1, C_BUS = 2'd2;

  state_t          state, nxt;
  logic [TO_W-1:0] cnt;
  logic [1:0]      cause_nxt;
  logic [3:0]      alu4, alu_fn;

  // instruction decode
  logic is_r, md_ok;
  logic d_alur, d_jr, d_jalr, d_mf, d_md, d_ialu, d_andor, d_br, d_lw, d_sw, d_j, d_jal, legal;
  assign is_r    = (Op == 6'h00);
  assign md_ok   = (MULDIV_EN != 0);
  assign d_alur  = is_r && (Funct inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                          6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02});
  assign d_jr    = is_r && (Funct == 6'h08);
  assign d_jalr  = is_r && (Funct == 6'h09);
  assign d_mf    = is_r && md_ok && (Funct == 6'h10 || Funct == 6'h12);
  assign d_md    = is_r && md_ok && (Funct[5:2] == 4'b0110);
  assign d_ialu  = Op inside {6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F};
  assign d_andor = (Op == 6'h0C) || (Op == 6'h0D);
  assign d_br    = (Op == 6'h04) || (Op == 6'h05);
  assign d_lw    = (Op == 6'h23);
  assign d_sw    = (Op == 6'h2B);
  assign d_j     = (Op == 6'h02);
  assign d_jal   = (Op == 6'h03);
  assign legal   = d_alur | d_jr | d_jalr | d_mf | d_md | d_ialu | d_br | d_lw | d_sw | d_j | d_jal;

  always_comb begin
    alu_fn = A_ADD;
    if (is_r) begin
      case (Funct)
        6'h22, 6'h23: alu_fn = A_SUB;
        6'h24:        alu_fn = A_AND;
        6'h25:        alu_fn = A_OR;
        6'h27:        alu_fn = A_NOR;
        6'h2A:        alu_fn = A_SLT;
        6'h2B:        alu_fn = A_SLTU;
        6'h00:        alu_fn = A_SLL;
        6'h02:        alu_fn = A_SRL;
        default:      alu_fn = A_ADD;
      endcase
    end else begin
      case (Op)
        6'h04, 6'h05: alu_fn = A_SUB;
        6'h0A:        alu_fn = A_SLT;
        6'h0B:        alu_fn = A_SLTU;
        6'h0C:        alu_fn = A_AND;
        6'h0D:        alu_fn = A_OR;
        6'h0F:        alu_fn = A_LUI;
        default:      alu_fn = A_ADD;
      endcase
    end
  end

  logic to_hit;
  assign to_hit = (cnt == TO_W'(MEM_TIMEOUT)) && !mem_ack;

  always_comb begin
    nxt = S_IF; cause_nxt = 2'd0;
    MemReq = 1'b0; MemWrite = 1'b0; IorD = 1'b0; PCWrite = 1'b0; IRWrite = 1'b0;
    RegWrite = 1'b0; EXTOp = 1'b1; ALUSrcA = 1'b1; ALUSrcB = 2'd0; alu4 = A_ADD;
    PCSource = 3'd0; GPRSel = 2'd0; WDSel = 2'd0; md_start = 1'b0; md_op = Funct[1:0];
    case (state)
      S_IF: begin
        MemReq = 1'b1; ALUSrcA = 1'b0; ALUSrcB = 2'd1; nxt = S_IF;
        if (mem_ack) begin PCWrite = 1'b1; IRWrite = 1'b1; nxt = S_ID; end
        else if (to_hit) begin nxt = S_EXC; cause_nxt = C_BUS; end
      end
      S_ID: begin
        if (!legal) begin
          nxt = S_EXC; cause_nxt = C_ILL;
        end else if (d_j || d_jal) begin
          PCSource = 3'd2; PCWrite = 1'b1;
          if (d_jal) begin RegWrite = 1'b1; WDSel = 2'd2; GPRSel = 2'd2; end
          nxt = S_IF;
        end else if (d_jr || d_jalr) begin
          nxt = S_EXE;
        end else begin
          // branch target computed speculatively while the register file is read
          ALUSrcA = 1'b0; ALUSrcB = 2'd3; nxt = S_EXE;
        end
      end
      S_EXE: begin
        alu4 = alu_fn; nxt = S_WB;
        if (d_br) begin
          PCSource = 3'd1; PCWrite = (Op == 6'h04) ? Zero : !Zero; nxt = S_IF;
        end else if (d_lw || d_sw) begin
          ALUSrcB = 2'd2; nxt = S_MEM;
        end else if (d_jr || d_jalr) begin
          PCSource = 3'd3; PCWrite = 1'b1;
          if (d_jalr) begin RegWrite = 1'b1; WDSel = 2'd2; GPRSel = 2'd2; end
          nxt = S_IF;
        end else if (d_md) begin
          if (!md_busy) begin md_start = 1'b1; nxt = S_MDW; end
          else nxt = S_EXE;
        end else if (d_ialu) begin
          ALUSrcB = 2'd2; EXTOp = !d_andor;
        end
      end
      S_MEM: begin
        MemReq = 1'b1; IorD = 1'b1; MemWrite = d_sw; nxt = S_MEM;
        if (mem_ack) nxt = d_sw ? S_IF : S_WB;
        else if (to_hit) begin nxt = S_EXC; cause_nxt = C_BUS; end
      end
      S_WB: begin
        RegWrite = 1'b1; nxt = S_IF;
        if (d_lw) begin WDSel = 2'd1; GPRSel = 2'd1; end
        else if (d_ialu) GPRSel = 2'd1;
        else if (d_mf) WDSel = 2'd3;
      end
      S_MDW: nxt = md_busy ? S_MDW : S_IF;
      S_EXC: begin PCSource = 3'd4; PCWrite = 1'b1; nxt = S_IF; end
      default: nxt = S_IF;
    endcase
    // reset kills every side effect in the same cycle, not just at the next edge
    if (rst) begin
      MemReq = 1'b0; MemWrite = 1'b0; PCWrite = 1'b0; IRWrite = 1'b0;
      RegWrite = 1'b0; md_start = 1'b0;
    end
  end

  always_comb begin
    ALUOp      = '0;
    ALUOp[3:0] = alu4;
  end
  assign state_o = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IF;
      cnt       <= '0;
      exc_valid <= 1'b0;
      exc_cause <= 2'd0;
    end else begin
      state     <= nxt;
      exc_valid <= (nxt == S_EXC);
      if (nxt == S_EXC) exc_cause <= cause_nxt;
      if (nxt != state) cnt <= '0;
      else if (state == S_IF || state == S_MEM) cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Bench for mc_ctrl_hs: per-instruction expected cycle traces built from the
// instruction's phase sequence, replayed with random handshake delays.
module tb_mc_ctrl_hs;
  localparam int TO = 15;
  localparam logic [2:0] IF = 0, ID = 1, EXE = 2, MEM = 3, WB = 4, MDW = 5, EXC = 6;

  logic clk = 1'b0, rst = 1'b1, Zero = 1'b0, mem_ack = 1'b0, md_busy = 1'b0;
  logic [5:0] Op = 6'h0, Funct = 6'h0;

  logic MemReq, MemWrite, IorD, PCWrite, IRWrite, RegWrite, EXTOp, ALUSrcA;
  logic [1:0] ALUSrcB, GPRSel, WDSel, md_op, exc_cause;
  logic [3:0] ALUOp;
  logic [2:0] PCSource, state_o;
  logic md_start, exc_valid;

  logic z_MemReq, z_MemWrite, z_IorD, z_PCWrite, z_IRWrite, z_RegWrite, z_EXTOp, z_ALUSrcA;
  logic [1:0] z_ALUSrcB, z_GPRSel, z_WDSel, z_md_op, z_exc_cause;
  logic [3:0] z_ALUOp;
  logic [2:0] z_PCSource, z_state_o;
  logic z_md_start, z_exc_valid;

  mc_ctrl_hs #(.ALUOP_W(4), .TO_W(4), .MEM_TIMEOUT(TO), .MULDIV_EN(1)) dut (
    .clk(clk), .rst(rst), .Zero(Zero), .Op(Op), .Funct(Funct), .mem_ack(mem_ack),
    .md_busy(md_busy), .MemReq(MemReq), .MemWrite(MemWrite), .IorD(IorD),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .EXTOp(EXTOp),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .GPRSel(GPRSel), .WDSel(WDSel), .md_start(md_start), .md_op(md_op),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .state_o(state_o));

  mc_ctrl_hs #(.ALUOP_W(4), .TO_W(4), .MEM_TIMEOUT(TO), .MULDIV_EN(0)) dut_nomd (
    .clk(clk), .rst(rst), .Zero(Zero), .Op(Op), .Funct(Funct), .mem_ack(mem_ack),
    .md_busy(md_busy), .MemReq(z_MemReq), .MemWrite(z_MemWrite), .IorD(z_IorD),
    .PCWrite(z_PCWrite), .IRWrite(z_IRWrite), .RegWrite(z_RegWrite), .EXTOp(z_EXTOp),
    .ALUSrcA(z_ALUSrcA), .ALUSrcB(z_ALUSrcB), .ALUOp(z_ALUOp), .PCSource(z_PCSource),
    .GPRSel(z_GPRSel), .WDSel(z_WDSel), .md_start(z_md_start), .md_op(z_md_op),
    .exc_valid(z_exc_valid), .exc_cause(z_exc_cause), .state_o(z_state_o));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic mreq, mwr, iord, pcw, irw, rw;
    logic [2:0] pcs;
    logic [1:0] wd, gpr;
    logic mds;
    logic [1:0] mdop, srcb;
    logic ext;
    logic [3:0] aop;
    logic excv;
    logic [1:0] cause;
  } obs_t;
  typedef struct { obs_t e; logic ack, busy, zero; } ent_t;
  typedef enum int { K_ADDU, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_JR, K_JALR,
                     K_DIV, K_MFLO, K_ORI, K_ILL } kind_t;

  ent_t q[$];
  logic [1:0] cur_cause = 2'd0;
  logic [5:0] cur_fn = 6'h0;
  int passed = 0, total = 0, cyc = 0;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, o, e);
  endtask

  function automatic logic rb();
    return logic'($urandom % 2);
  endfunction

  // what every state drives regardless of instruction
  function automatic obs_t base(input logic [2:0] st);
    obs_t o = '0;
    o.st = st; o.ext = 1'b1; o.aop = 4'd1; o.cause = cur_cause; o.mdop = cur_fn[1:0];
    case (st)
      IF:  begin o.mreq = 1; o.srcb = 2'd1; end
      MEM: begin o.mreq = 1; o.iord = 1; end
      WB:  o.rw = 1;
      EXC: begin o.pcs = 3'd4; o.pcw = 1; o.excv = 1; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic obs_t obs_dut();
    obs_t o;
    o.st = state_o; o.mreq = MemReq; o.mwr = MemWrite; o.iord = IorD; o.pcw = PCWrite;
    o.irw = IRWrite; o.rw = RegWrite; o.pcs = PCSource; o.wd = WDSel; o.gpr = GPRSel;
    o.mds = md_start; o.mdop = md_op; o.srcb = ALUSrcB; o.ext = EXTOp; o.aop = ALUOp;
    o.excv = exc_valid; o.cause = exc_cause;
    return o;
  endfunction

  task automatic push(input obs_t o, input logic a, input logic b, input logic z);
    ent_t en;
    en.e = o; en.ack = a; en.busy = b; en.zero = z;
    q.push_back(en);
  endtask

  // Expected trace of one instruction as a list of cycles
  task automatic build(input kind_t k, input int dif, input int dmem, input bit mem_to,
                       input bit ack_at_to, input logic z, input int bexe, input int bmdw);
    obs_t o;
    if (dif > TO) begin
      for (int i = 0; i <= TO; i++) push(base(IF), 1'b0, rb(), rb());
      cur_cause = 2'd2; push(base(EXC), rb(), rb(), rb());
      return;
    end
    for (int i = 0; i <= dif; i++) begin
      o = base(IF);
      if (i == dif) begin o.pcw = 1; o.irw = 1; end
      push(o, logic'(i == dif), rb(), rb());
    end
    o = base(ID);
    case (k)
      K_J:   begin o.pcs = 3'd2; o.pcw = 1; end
      K_JAL: begin o.pcs = 3'd2; o.pcw = 1; o.rw = 1; o.wd = 2'd2; o.gpr = 2'd2; end
      K_JR, K_JALR, K_ILL: ;
      default: o.srcb = 2'd3;
    endcase
    push(o, rb(), rb(), rb());
    if (k == K_J || k == K_JAL) return;
    if (k == K_ILL) begin cur_cause = 2'd1; push(base(EXC), rb(), rb(), rb()); return; end
    o = base(EXE);
    case (k)
      K_BEQ, K_BNE: begin
        o.aop = 4'd2; o.pcs = 3'd1; o.pcw = (k == K_BEQ) ? z : !z;
        push(o, rb(), rb(), z); return;
      end
      K_JR:   begin o.pcs = 3'd3; o.pcw = 1; push(o, rb(), rb(), rb()); return; end
      K_JALR: begin
        o.pcs = 3'd3; o.pcw = 1; o.rw = 1; o.wd = 2'd2; o.gpr = 2'd2;
        push(o, rb(), rb(), rb()); return;
      end
      K_DIV: begin
        for (int i = 0; i < bexe; i++) push(base(EXE), rb(), 1'b1, rb());
        o.mds = 1; push(o, rb(), 1'b0, rb());
        for (int i = 0; i < bmdw; i++) push(base(MDW), rb(), 1'b1, rb());
        push(base(MDW), rb(), 1'b0, rb());
        return;
      end
      K_LW, K_SW: begin o.srcb = 2'd2; push(o, rb(), rb(), rb()); end
      K_ORI:      begin o.srcb = 2'd2; o.ext = 0; o.aop = 4'd4; push(o, rb(), rb(), rb()); end
      default: push(o, rb(), rb(), rb());
    endcase
    if (k == K_LW || k == K_SW) begin
      int n = mem_to ? TO : dmem;
      for (int i = 0; i <= n; i++) begin
        o = base(MEM); o.mwr = (k == K_SW);
        push(o, mem_to ? logic'(ack_at_to && i == TO) : logic'(i == dmem), rb(), rb());
      end
      if (mem_to && !ack_at_to) begin cur_cause = 2'd2; push(base(EXC), rb(), rb(), rb()); return; end
      if (k == K_SW) return;
    end
    o = base(WB);
    if (k == K_LW) begin o.wd = 2'd1; o.gpr = 2'd1; end
    else if (k == K_ORI) o.gpr = 2'd1;
    else if (k == K_MFLO) o.wd = 2'd3;
    push(o, rb(), rb(), rb());
  endtask

  // Called and returns at a falling edge; inputs change there, outputs sampled 1ns later
  task automatic run_q(input int limit);
    ent_t en;
    int n = 0;
    while (q.size() > 0 && n < limit) begin
      en = q.pop_front();
      mem_ack = en.ack; md_busy = en.busy; Zero = en.zero;
      #1;
      chk($sformatf("cyc%0d_st%0d", cyc, en.e.st), 64'(obs_dut()), 64'(en.e));
      cyc++; n++;
      @(negedge clk);
    end
  endtask

  task automatic do_instr(input kind_t k, input int dif, input int dmem, input bit mem_to,
                          input bit ack_at_to, input logic z, input int bexe, input int bmdw);
    logic [5:0] op, fn;
    fn = 6'($urandom);
    case (k)
      K_ADDU: begin op = 6'h00; fn = 6'h21; end
      K_LW:   op = 6'h23;
      K_SW:   op = 6'h2B;
      K_BEQ:  op = 6'h04;
      K_BNE:  op = 6'h05;
      K_J:    op = 6'h02;
      K_JAL:  op = 6'h03;
      K_JR:   begin op = 6'h00; fn = 6'h08; end
      K_JALR: begin op = 6'h00; fn = 6'h09; end
      K_DIV:  begin op = 6'h00; fn = 6'h1A; end
      K_MFLO: begin op = 6'h00; fn = 6'h12; end
      K_ORI:  op = 6'h0D;
      default: op = 6'h3F;
    endcase
    Op = op; Funct = fn; cur_fn = fn;
    build(k, dif, dmem, mem_to, ack_at_to, z, bexe, bmdw);
    run_q(1000);
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_ack = 1'b0; md_busy = 1'b0;
    #1;
    chk("rst_state", 64'(state_o), 64'(IF));
    chk("rst_excv_cause", 64'({exc_valid, exc_cause}), 64'(0));
    chk("rst_enables", 64'({MemReq, MemWrite, RegWrite, PCWrite}), 64'(0));
    @(negedge clk); @(negedge clk);
    rst = 1'b0; cur_cause = 2'd0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    do_instr(K_ADDU, 0, 0, 0, 0, 0, 0, 0);
    do_instr(K_LW,   2, 2, 0, 0, 0, 0, 0);
    do_instr(K_SW,   0, 0, 1, 0, 0, 0, 0);   // bus timeout in MEM
    do_instr(K_SW,   1, 0, 1, 1, 0, 0, 0);   // ack on the timeout cycle wins
    do_instr(K_ADDU, 100, 0, 0, 0, 0, 0, 0); // bus timeout in IF
    do_instr(K_ILL,  0, 0, 0, 0, 0, 0, 0);
    do_instr(K_DIV,  0, 0, 0, 0, 0, 2, 5);
    do_instr(K_MFLO, 0, 0, 0, 0, 0, 0, 0);
    do_instr(K_BEQ,  0, 0, 0, 0, 1, 0, 0);
    do_instr(K_BEQ,  0, 0, 0, 0, 0, 0, 0);
    do_instr(K_BNE,  0, 0, 0, 0, 0, 0, 0);
    do_instr(K_BNE,  0, 0, 0, 0, 1, 0, 0);
    do_instr(K_J,    0, 0, 0, 0, 0, 0, 0);
    do_instr(K_JAL,  1, 0, 0, 0, 0, 0, 0);
    do_instr(K_JR,   0, 0, 0, 0, 0, 0, 0);
    do_instr(K_JALR, 0, 0, 0, 0, 0, 0, 0);
    do_instr(K_ORI,  0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++)
      do_instr(kind_t'($urandom_range(0, 12)), $urandom_range(0, 3), $urandom_range(0, 3),
               ($urandom % 8) == 0, rb(), rb(), $urandom_range(0, 2), $urandom_range(0, 3));

    // reset asserted mid-store: side effects must vanish before the next edge
    Op = 6'h2B; Funct = 6'h00; cur_fn = 6'h00;
    build(K_SW, 0, 8, 0, 0, 0, 0, 0);
    run_q(4);
    mem_ack = 1'b0; #1;
    chk("sw_mem_write", 64'({state_o, MemWrite}), 64'({MEM, 1'b1}));
    #1 rst = 1'b1; #1;
    chk("rst_mid_state", 64'(state_o), 64'(IF));
    chk("rst_mid_memwr", 64'({MemReq, MemWrite, RegWrite}), 64'(0));
    q.delete();
    @(negedge clk); @(negedge clk);
    rst = 1'b0; cur_cause = 2'd0;

    // without mul/div support, div is illegal
    do_reset();
    Op = 6'h00; Funct = 6'h1A; mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0; #1;
    chk("nomd_id", 64'(z_state_o), 64'(ID));
    @(negedge clk); #1;
    chk("nomd_exc", 64'({z_state_o, z_exc_valid, z_exc_cause, z_PCSource}),
        64'({EXC, 1'b1, 2'd1, 3'd4}));
    chk("md_exe", 64'(state_o), 64'(EXE));
    @(negedge clk);
    do_reset();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached passed=%0d total=%0d", passed, total);
    $fatal(1, "timeout");
  end
endmodule
